// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, cache-miss freeze,
// taken-branch flush and HLT drain, driving the pipeline register enables.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MISS_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       IFID_SrcReg1,
  input  logic [3:0]       IFID_SrcReg2,
  input  logic             IFID_use1,
  input  logic             IFID_use2,
  input  logic             IFID_MemWrite,
  input  logic             IDEX_MemRead,
  input  logic [3:0]       IDEX_DstReg,
  input  logic             Branch_taken,
  input  logic             Halt_ID,
  input  logic             IF_miss,
  input  logic             MEM_miss,
  output logic             PC_wen,
  output logic             IFID_wen,
  output logic             IFID_flush,
  output logic             IDEX_wen,
  output logic             IDEX_nop,
  output logic             EXMEM_wen,
  output logic             MEMWB_nop,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;
  localparam int MISS_W  = $clog2(MISS_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, HALT_DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic [MISS_W-1:0]  miss_cnt;
  logic               load_use;

  // Store data (Src2 of SW) is forwarded MEM->MEM, so it never needs the stall.
  assign load_use = IDEX_MemRead && (IDEX_DstReg != 4'd0) &&
                    ((IFID_use1 && (IFID_SrcReg1 == IDEX_DstReg)) ||
                     (IFID_use2 && (IFID_SrcReg2 == IDEX_DstReg) && !IFID_MemWrite));

  assign halted = (state == DONE);

  // NOTE: every output and next-state value gets a default first, so no path
  // through the priority chain can leave a variable unassigned and infer a latch.
  always_comb begin
    PC_wen     = 1'b1;
    IFID_wen   = 1'b1;
    IFID_flush = 1'b0;
    IDEX_wen   = 1'b1;
    IDEX_nop   = 1'b0;
    EXMEM_wen  = 1'b1;
    MEMWB_nop  = 1'b0;
    state_nxt  = state;
    drain_nxt  = drain_cnt;

    // Reset is decoded combinationally so the pipeline freezes the moment rst drops.
    if (!rst || state == DONE) begin
      PC_wen     = 1'b0;
      IFID_wen   = 1'b0;
      IFID_flush = 1'b1;
      IDEX_wen   = 1'b0;
      IDEX_nop   = 1'b1;
      EXMEM_wen  = 1'b0;
      MEMWB_nop  = 1'b1;
    end else if (MEM_miss) begin
      PC_wen    = 1'b0;
      IFID_wen  = 1'b0;
      IDEX_wen  = 1'b0;
      EXMEM_wen = 1'b0;
      MEMWB_nop = 1'b1;
    end else if (state == HALT_DRAIN) begin
      PC_wen     = 1'b0;
      IFID_flush = 1'b1;
      drain_nxt  = drain_cnt + 1'b1;
      if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state_nxt = DONE;
    end else if (load_use) begin
      PC_wen   = 1'b0;
      IFID_wen = 1'b0;
      IDEX_nop = 1'b1;
    end else if (Branch_taken) begin
      IFID_flush = 1'b1;
    end else if (IF_miss) begin
      PC_wen     = 1'b0;
      IFID_flush = 1'b1;
    end else if (Halt_ID) begin
      PC_wen     = 1'b0;
      IFID_flush = 1'b1;
      state_nxt  = HALT_DRAIN;
      drain_nxt  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      drain_cnt   <= '0;
      miss_cnt    <= '0;
      timeout_err <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;

      if (MEM_miss) begin
        if (miss_cnt != MISS_W'(MISS_TIMEOUT)) miss_cnt <= miss_cnt + 1'b1;
        if (miss_cnt == MISS_W'(MISS_TIMEOUT - 1)) timeout_err <= 1'b1;
      end else begin
        miss_cnt <= '0;
      end

      if (!PC_wen && state != DONE && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic compared cycle by cycle against a behavioural model of the rules.
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN_CYCLES = 3;
  localparam int MISS_TIMEOUT = 64;
  localparam int CNT_W        = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] IFID_SrcReg1 = '0, IFID_SrcReg2 = '0, IDEX_DstReg = '0;
  logic IFID_use1 = 0, IFID_use2 = 0, IFID_MemWrite = 0, IDEX_MemRead = 0;
  logic Branch_taken = 0, Halt_ID = 0, IF_miss = 0, MEM_miss = 0;
  logic PC_wen, IFID_wen, IFID_flush, IDEX_wen, IDEX_nop, EXMEM_wen, MEMWB_nop;
  logic halted, timeout_err;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Model state: 0 running, 1 draining, 2 halted.
  int          m_mode;
  int          m_drained;
  int          m_miss_run;
  bit          m_terr;
  int unsigned m_stalls;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES(DRAIN_CYCLES), .MISS_TIMEOUT(MISS_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .IFID_SrcReg1(IFID_SrcReg1), .IFID_SrcReg2(IFID_SrcReg2),
    .IFID_use1(IFID_use1), .IFID_use2(IFID_use2), .IFID_MemWrite(IFID_MemWrite),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_DstReg(IDEX_DstReg),
    .Branch_taken(Branch_taken), .Halt_ID(Halt_ID), .IF_miss(IF_miss), .MEM_miss(MEM_miss),
    .PC_wen(PC_wen), .IFID_wen(IFID_wen), .IFID_flush(IFID_flush),
    .IDEX_wen(IDEX_wen), .IDEX_nop(IDEX_nop), .EXMEM_wen(EXMEM_wen), .MEMWB_nop(MEMWB_nop),
    .halted(halted), .timeout_err(timeout_err), .stall_cnt(stall_cnt)
  );

  function automatic logic [8:0] observed();
    return {PC_wen, IFID_wen, IFID_flush, IDEX_wen, IDEX_nop, EXMEM_wen, MEMWB_nop,
            halted, timeout_err};
  endfunction

  function automatic bit hazard();
    return IDEX_MemRead && IDEX_DstReg != 0 &&
           ((IFID_use1 && IFID_SrcReg1 == IDEX_DstReg) ||
            (IFID_use2 && IFID_SrcReg2 == IDEX_DstReg && !IFID_MemWrite));
  endfunction

  // Expected {PC,IFID wen,IFID flush,IDEX wen,IDEX nop,EXMEM wen,MEMWB nop,halted,timeout}.
  function automatic logic [8:0] expected();
    logic [6:0] ctl;
    if (!rst)                ctl = 7'b0010101;
    else if (m_mode == 2)    ctl = 7'b0010101;
    else if (MEM_miss)       ctl = 7'b0000001;
    else if (m_mode == 1)    ctl = 7'b0111010;
    else if (hazard())       ctl = 7'b0001110;
    else if (Branch_taken)   ctl = 7'b1111010;
    else if (IF_miss)        ctl = 7'b0111010;
    else if (Halt_ID)        ctl = 7'b0111010;
    else                     ctl = 7'b1101010;
    return {ctl, rst && m_mode == 2, rst && m_terr};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_drained = 0; m_miss_run = 0; m_terr = 0; m_stalls = 0;
  endtask

  task automatic model_clock(input logic [8:0] exp_v);
    if (exp_v[8] == 1'b0 && m_mode != 2 && m_stalls < (2 ** CNT_W) - 1) m_stalls++;
    if (m_mode == 0 && !MEM_miss && !hazard() && !Branch_taken && !IF_miss && Halt_ID) begin
      m_mode = 1; m_drained = 0;
    end else if (m_mode == 1 && !MEM_miss) begin
      m_drained++;
      if (m_drained == DRAIN_CYCLES) m_mode = 2;
    end
    m_miss_run = MEM_miss ? m_miss_run + 1 : 0;
    if (m_miss_run >= MISS_TIMEOUT) m_terr = 1;
  endtask

  // Inputs are driven at the falling edge; compare mid-cycle, then clock the model.
  task automatic cycle(input string tag);
    logic [8:0] e;
    #1;
    e = expected();
    checks++;
    if (observed() !== e) begin
      errors++;
      $display("FAIL %s outputs: got %b want %b (t=%0t)", tag, observed(), e, $time);
    end
    checks++;
    if (stall_cnt !== CNT_W'(m_stalls)) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d want %0d (t=%0t)", tag, stall_cnt, m_stalls, $time);
    end
    @(posedge clk);
    model_clock(e);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    IFID_SrcReg1 = 0; IFID_SrcReg2 = 0; IDEX_DstReg = 0;
    IFID_use1 = 0; IFID_use2 = 0; IFID_MemWrite = 0; IDEX_MemRead = 0;
    Branch_taken = 0; Halt_ID = 0; IF_miss = 0; MEM_miss = 0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must return to reset values at once.
  task automatic apply_reset(input string tag);
    rst = 1'b0;
    #2;
    checks++;
    if ({observed(), stall_cnt} !== {9'b0010101_00, CNT_W'(0)}) begin
      errors++;
      $display("FAIL %s reset: got %b/%0d want 001010100/0", tag, observed(), stall_cnt);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    MEM_miss = 1; Branch_taken = 1;
    #1;
    checks++;
    if ({observed(), stall_cnt} !== {9'b0010101_00, CNT_W'(0)}) begin
      errors++;
      $display("FAIL reset_hold: got %b/%0d want 001010100/0", observed(), stall_cnt);
    end
    @(negedge clk);
    clear_inputs();
    model_reset();
    rst = 1'b1;
    cycle("reset_release");
  endtask

  task automatic test_load_use();
    apply_reset("lu");
    IDEX_MemRead = 1; IDEX_DstReg = 3; IFID_SrcReg1 = 3; IFID_use1 = 1;
    cycle("lu_stall");
    checks++;
    if (stall_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL lu_count: got %0d want 1", stall_cnt);
    end
    IDEX_MemRead = 0;
    cycle("lu_release");
    IDEX_MemRead = 1; IDEX_DstReg = 0; IFID_SrcReg1 = 0;
    cycle("lu_r0");
    IDEX_DstReg = 3; IFID_use1 = 0; IFID_SrcReg2 = 3; IFID_use2 = 1; IFID_MemWrite = 1;
    cycle("lu_sw_data");
    IFID_MemWrite = 0; Branch_taken = 1; Halt_ID = 1;
    cycle("lu_rt_over_branch");
    clear_inputs();
    cycle("lu_after");
  endtask

  task automatic test_mem_miss_branch();
    apply_reset("mm");
    MEM_miss = 1; Branch_taken = 1;
    for (int i = 0; i < 5; i++) cycle("mm_freeze");
    checks++;
    if (stall_cnt !== CNT_W'(5)) begin
      errors++;
      $display("FAIL mm_count: got %0d want 5", stall_cnt);
    end
    MEM_miss = 0;
    cycle("mm_resume_branch");
    clear_inputs();
  endtask

  task automatic test_branch_ifmiss();
    apply_reset("br");
    Branch_taken = 1; IF_miss = 1;
    cycle("br_over_ifmiss");
    Branch_taken = 0;
    cycle("ifmiss_alone");
    clear_inputs();
    cycle("br_idle");
  endtask

  task automatic test_halt_drain();
    int edges;
    apply_reset("halt");
    Halt_ID = 1;
    cycle("halt_enter");
    Halt_ID = 0;
    edges = 1;
    while (halted !== 1'b1 && edges < 20) begin
      MEM_miss = (edges == 2 || edges == 3);
      cycle("halt_drain");
      edges++;
    end
    MEM_miss = 0;
    checks++;
    if (edges != 1 + DRAIN_CYCLES + 2) begin
      errors++;
      $display("FAIL halt_latency: got %0d cycles want %0d", edges, 1 + DRAIN_CYCLES + 2);
    end
    for (int i = 0; i < 4; i++) begin
      Branch_taken = 1'($urandom); MEM_miss = 1'($urandom); IF_miss = 1'($urandom);
      cycle("halt_done_hold");
    end
    clear_inputs();
    apply_reset("halt_exit");
    cycle("halt_after_reset");
  endtask

  task automatic test_timeout();
    apply_reset("to");
    MEM_miss = 1;
    for (int i = 0; i < 70; i++) begin
      cycle("to_miss");
      if (i == MISS_TIMEOUT - 2 || i == MISS_TIMEOUT - 1) begin
        checks++;
        if (timeout_err !== (i == MISS_TIMEOUT - 1)) begin
          errors++;
          $display("FAIL to_edge: after %0d misses got %b", i + 1, timeout_err);
        end
      end
    end
    MEM_miss = 0;
    cycle("to_sticky");
    MEM_miss = 1;
    cycle("to_midmiss");
    apply_reset("to_midmiss");
    MEM_miss = 0;
    cycle("to_cleared");
  endtask

  task automatic test_random();
    apply_reset("rnd");
    for (int i = 0; i < 600; i++) begin
      IFID_SrcReg1  = 4'($urandom_range(0, 3));
      IFID_SrcReg2  = 4'($urandom_range(0, 3));
      IDEX_DstReg   = 4'($urandom_range(0, 3));
      IFID_use1     = 1'($urandom);
      IFID_use2     = 1'($urandom);
      IFID_MemWrite = 1'($urandom);
      IDEX_MemRead  = 1'($urandom);
      Branch_taken  = ($urandom_range(0, 3) == 0);
      IF_miss       = ($urandom_range(0, 3) == 0);
      MEM_miss      = ($urandom_range(0, 4) == 0);
      Halt_ID       = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 79) == 0) apply_reset("rnd_mid");
      else cycle("rnd");
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mem_miss_branch();
    test_branch_ifmiss();
    test_halt_drain();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
